// File: rtl/reg_read_dispatch_if.sv
// Operand-fetch bus bundle: issue request, register-file read port,
// write-back snoop and the operand handshake towards the consumers.
interface reg_read_dispatch_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [1:0]            issue_dst;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic                  issue_use_rs2;

  logic [REG_ADDR_W-1:0] rf_read_addr;
  logic [XLEN-1:0]       rf_read_data;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_dst;
  logic [XLEN-1:0]       out_op_a;
  logic [XLEN-1:0]       out_op_b;

  // Environment side: issue stage, register file, write-back path, consumer.
  modport master (
    output issue_valid, issue_dst, issue_rs1, issue_rs2, issue_use_rs2,
    output rf_read_data, wb_en, wb_addr, wb_data, out_ready,
    input  issue_ready, rf_read_addr, out_valid, out_dst, out_op_a, out_op_b
  );

  // Dispatch block side.
  modport slave (
    input  issue_valid, issue_dst, issue_rs1, issue_rs2, issue_use_rs2,
    input  rf_read_data, wb_en, wb_addr, wb_data, out_ready,
    output issue_ready, rf_read_addr, out_valid, out_dst, out_op_a, out_op_b
  );
endinterface

// File: rtl/reg_read_dispatch.sv
// Register read dispatch: fetches up to two operands for one issued
// instruction through a single RF read port, bypassing same-cycle
// write-back data and forcing x0 to zero, then holds the operand pair
// on a valid/ready handshake until the selected consumer takes it.
module reg_read_dispatch #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic              clk,
  input logic              reset,
  reg_read_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StReadA,
    StReadB,
    StHold
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            dst_q, dst_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic                  use_rs2_q, use_rs2_d;
  logic [XLEN-1:0]       op_a_q, op_a_d;
  logic [XLEN-1:0]       op_b_q, op_b_d;

  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_value;

  // Read address and the resolved operand value for the register read this cycle.
  always_comb begin
    rd_addr = '0;
    unique case (state_q)
      StReadA: rd_addr = rs1_q;
      StReadB: rd_addr = rs2_q;
      default: rd_addr = '0;
    endcase

    // x0 beats the bypass, the bypass beats the register file.
    if (rd_addr == '0) begin
      rd_value = '0;
    end else if (bus.wb_en && (bus.wb_addr == rd_addr)) begin
      rd_value = bus.wb_data;
    end else begin
      rd_value = bus.rf_read_data;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_rs2_d = use_rs2_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;

    unique case (state_q)
      StIdle: begin
        if (bus.issue_valid) begin
          dst_d     = bus.issue_dst;
          rs1_d     = bus.issue_rs1;
          rs2_d     = bus.issue_rs2;
          use_rs2_d = bus.issue_use_rs2;
          // dst 00 is consumed without producing a bundle.
          if (bus.issue_dst != 2'b00) begin
            state_d = StReadA;
          end
        end
      end
      StReadA: begin
        op_a_d = rd_value;
        if (use_rs2_q) begin
          state_d = StReadB;
        end else begin
          op_b_d  = '0;
          state_d = StHold;
        end
      end
      StReadB: begin
        op_b_d  = rd_value;
        state_d = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and operand registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      dst_q     <= 2'b00;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs2_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      use_rs2_q <= use_rs2_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  assign bus.issue_ready  = (state_q == StIdle);
  assign bus.rf_read_addr = rd_addr;
  assign bus.out_valid    = (state_q == StHold);
  assign bus.out_dst      = dst_q;
  assign bus.out_op_a     = op_a_q;
  assign bus.out_op_b     = op_b_q;

endmodule
